// File: rtl/ctrl_fsm_regdst_pkg.sv
// ctrl_fsm_regdst_pkg
//   Shared definitions for the multi-cycle CPU control path: opcode values,
//   FSM state encoding, instruction classes and the destination-register mux
//   select codes.
//   No ports (package).
package ctrl_fsm_regdst_pkg;

  // Opcodes carried in ir[15:12]; 8..15 are undefined.
  localparam logic [3:0] OPC_NOP   = 4'd0;
  localparam logic [3:0] OPC_ALU   = 4'd1;
  localparam logic [3:0] OPC_ADDI  = 4'd2;
  localparam logic [3:0] OPC_LOAD  = 4'd3;
  localparam logic [3:0] OPC_STORE = 4'd4;
  localparam logic [3:0] OPC_JAL   = 4'd5;
  localparam logic [3:0] OPC_BEQ   = 4'd6;
  localparam logic [3:0] OPC_HALT  = 4'd7;

  // Select codes for the downstream 4:1 destination-register mux.
  localparam logic [1:0] SEL_RD   = 2'b00;
  localparam logic [1:0] SEL_RT   = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // JAL always writes the link register r7.
  localparam logic [2:0] LINK_REG = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_ADDI    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } op_class_e;

endpackage

// File: rtl/ctrl_fsm_regdst_instr_field_decode.sv
// instr_field_decode
//   Combinational opcode decoder: classifies an instruction and reports the
//   destination-mux select and which optional phases (MEM, WB) it needs.
// Ports:
//   opcode_i     in  4 : instruction opcode field
//   op_class_o   out   : instruction class
//   dst_sel_o    out 2 : destination mux select (SEL_RD when no writeback)
//   needs_mem_o  out 1 : instruction visits MEM
//   needs_wb_o   out 1 : instruction visits WB
//   is_illegal_o out 1 : opcode is undefined
module instr_field_decode
  import ctrl_fsm_regdst_pkg::*;
(
  input  logic [3:0] opcode_i,
  output op_class_e  op_class_o,
  output logic [1:0] dst_sel_o,
  output logic       needs_mem_o,
  output logic       needs_wb_o,
  output logic       is_illegal_o
);

  always_comb begin
    op_class_o   = CLS_ILLEGAL;
    dst_sel_o    = SEL_RD;
    needs_mem_o  = 1'b0;
    needs_wb_o   = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OPC_NOP:   op_class_o = CLS_NOP;
      OPC_ALU: begin
        op_class_o = CLS_ALU;
        dst_sel_o  = SEL_RD;
        needs_wb_o = 1'b1;
      end
      OPC_ADDI: begin
        op_class_o = CLS_ADDI;
        dst_sel_o  = SEL_RT;
        needs_wb_o = 1'b1;
      end
      OPC_LOAD: begin
        op_class_o  = CLS_LOAD;
        dst_sel_o   = SEL_RT;
        needs_mem_o = 1'b1;
        needs_wb_o  = 1'b1;
      end
      OPC_STORE: begin
        op_class_o  = CLS_STORE;
        needs_mem_o = 1'b1;
      end
      OPC_JAL: begin
        op_class_o = CLS_JAL;
        dst_sel_o  = SEL_LINK;
        needs_wb_o = 1'b1;
      end
      OPC_BEQ:   op_class_o = CLS_BEQ;
      OPC_HALT:  op_class_o = CLS_HALT;
      default:   is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_regdst.sv
// ctrl_fsm_regdst
//   Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB per instruction.
//   Latches the instruction, exposes the register-address fields and the
//   destination-mux select, and issues the writeback and PC-advance strobes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : leave IDLE
//   imem_req/ack/rdata  : instruction fetch handshake
//   dmem_req/we/ack     : data access handshake (we=1 for STORE)
//   rd/rt/rs_addr       : ir[11:9], ir[5:3], ir[8:6]
//   link_addr           : constant r7 (mux in2)
//   reg_dst_sel         : destination mux select, DECODE..WB, else 00
//   reg_we, pc_en       : one-cycle strobes (WB / re-entry into FETCH)
//   alu_op              : ir[15:12]
//   halted, illegal     : HALT state, sticky undefined-opcode flag
module ctrl_fsm_regdst
  import ctrl_fsm_regdst_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic [2:0]    rd_addr,
  output logic [2:0]    rt_addr,
  output logic [2:0]    rs_addr,
  output logic [2:0]    link_addr,
  output logic [1:0]    reg_dst_sel,
  output logic          reg_we,
  output logic          pc_en,
  output logic [3:0]    alu_op,
  output logic          halted,
  output logic          illegal
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          illegal_q, illegal_d;
  logic          imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, pc_en_q, halted_q;
  logic [1:0]    reg_dst_sel_q;

  op_class_e     dec_class;
  logic [1:0]    dec_sel;
  logic          dec_mem, dec_wb, dec_illegal;

  // Decoding the next-cycle ir lets the select be valid in the very first
  // DECODE cycle; in every other state ir_d equals ir_q.
  assign ir_d = (state_q == ST_FETCH && imem_ack) ? imem_rdata : ir_q;

  instr_field_decode u_decode (
    .opcode_i     (ir_d[IW-1 -: 4]),
    .op_class_o   (dec_class),
    .dst_sel_o    (dec_sel),
    .needs_mem_o  (dec_mem),
    .needs_wb_o   (dec_wb),
    .is_illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (dec_class == CLS_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_mem)     state_d = ST_MEM;
        else if (dec_wb) state_d = ST_WB;
        else             state_d = ST_FETCH;
      end
      ST_MEM:    if (dmem_ack) state_d = dec_wb ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up exactly
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      illegal_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      reg_we_q      <= 1'b0;
      pc_en_q       <= 1'b0;
      halted_q      <= 1'b0;
      reg_dst_sel_q <= SEL_RD;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      illegal_q     <= illegal_d;
      imem_req_q    <= (state_d == ST_FETCH);
      dmem_req_q    <= (state_d == ST_MEM);
      dmem_we_q     <= (state_d == ST_MEM) && (dec_class == CLS_STORE);
      reg_we_q      <= (state_d == ST_WB);
      // IDLE->FETCH is the first fetch, so the PC is not advanced.
      pc_en_q       <= (state_d == ST_FETCH) &&
                       (state_q inside {ST_EXEC, ST_MEM, ST_WB});
      halted_q      <= (state_d == ST_HALT);
      reg_dst_sel_q <= (state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
                       ? dec_sel : SEL_RD;
    end
  end

  // Low immediate bits are consumed by the datapath, not by control.
  logic unused_imm;
  assign unused_imm = ^ir_q[2:0];

  assign imem_req    = imem_req_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign reg_we      = reg_we_q;
  assign pc_en       = pc_en_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign reg_dst_sel = reg_dst_sel_q;
  assign rd_addr     = ir_q[11:9];
  assign rs_addr     = ir_q[8:6];
  assign rt_addr     = ir_q[5:3];
  assign link_addr   = LINK_REG;
  assign alu_op      = ir_q[IW-1 -: 4];

endmodule

// File: tb/tb_ctrl_fsm_regdst.sv
// tb_ctrl_fsm_regdst
//   Directed bench for ctrl_fsm_regdst. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point, after the edge has
//   taken effect. ctl packs the strobes as
//   {imem_req, dmem_req, dmem_we, reg_we, pc_en, halted, illegal, sel[1:0]}.
module tb_ctrl_fsm_regdst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, reg_we, pc_en, halted, illegal;
  logic [2:0]  rd_addr, rt_addr, rs_addr, link_addr;
  logic [1:0]  reg_dst_sel;
  logic [3:0]  alu_op;
  logic [8:0]  ctl;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_fsm_regdst #(.IW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rd_addr     (rd_addr),
    .rt_addr     (rt_addr),
    .rs_addr     (rs_addr),
    .link_addr   (link_addr),
    .reg_dst_sel (reg_dst_sel),
    .reg_we      (reg_we),
    .pc_en       (pc_en),
    .alu_op      (alu_op),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {imem_req, dmem_req, dmem_we, reg_we, pc_en, halted, illegal, reg_dst_sel};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with a zero-wait ack; leaves the FSM in DECODE.
  task automatic fetch(input logic [15:0] instr);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL reset_ctl ctl=%b exp=%b", ctl, 9'b000000000); end
    n_cmp++;
    if ({rd_addr, rt_addr, rs_addr, link_addr, alu_op} !== {3'd0, 3'd0, 3'd0, 3'd7, 4'd0}) begin
      n_bad++; $display("FAIL reset_fields rd=%0d rt=%0d rs=%0d link=%0d op=%0d exp 0/0/0/7/0", rd_addr, rt_addr, rs_addr, link_addr, alu_op);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL idle_hold ctl=%b exp=%b", ctl, 9'b000000000); end
    $display("txn reset done");
  endtask

  task automatic test_spurious_idle();
    imem_ack = 1'b1; imem_rdata = 16'h1FFF; dmem_ack = 1'b1;
    step(); step();
    imem_ack = 1'b0; imem_rdata = 16'h0000; dmem_ack = 1'b0;
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL idle_ack_ctl ctl=%b exp=%b", ctl, 9'b000000000); end
    n_cmp++;
    if ({rd_addr, alu_op} !== 7'd0) begin n_bad++; $display("FAIL idle_ack_latch rd=%0d op=%0d exp 0/0", rd_addr, alu_op); end
    $display("txn spurious acks in IDLE");
  endtask

  task automatic test_alu();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (ctl !== 9'b100000000) begin n_bad++; $display("FAIL alu_fetch ctl=%b exp=%b", ctl, 9'b100000000); end
    fetch(16'h1A50);
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL alu_decode ctl=%b exp=%b", ctl, 9'b000000000); end
    n_cmp++;
    if ({rd_addr, rt_addr, rs_addr, alu_op} !== {3'd5, 3'd2, 3'd1, 4'd1}) begin
      n_bad++; $display("FAIL alu_fields rd=%0d rt=%0d rs=%0d op=%0d exp 5/2/1/1", rd_addr, rt_addr, rs_addr, alu_op);
    end
    step();
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL alu_exec ctl=%b exp=%b", ctl, 9'b000000000); end
    step();
    n_cmp++;
    if (ctl !== 9'b000100000) begin n_bad++; $display("FAIL alu_wb ctl=%b exp=%b", ctl, 9'b000100000); end
    step();
    n_cmp++;
    if (ctl !== 9'b100010000) begin n_bad++; $display("FAIL alu_pc_en ctl=%b exp=%b", ctl, 9'b100010000); end
    step();
    n_cmp++;
    if (ctl !== 9'b100000000) begin n_bad++; $display("FAIL fetch_wait ctl=%b exp=%b", ctl, 9'b100000000); end
    $display("txn ALU 1A50");
  endtask

  task automatic test_load_wait();
    int req_cycles;
    req_cycles = 0;
    fetch(16'h3028);
    n_cmp++;
    if ({ctl, rt_addr, alu_op} !== {9'b000000001, 3'd5, 4'd3}) begin
      n_bad++; $display("FAIL load_decode ctl=%b rt=%0d op=%0d exp %b/5/3", ctl, rt_addr, alu_op, 9'b000000001);
    end
    step();
    n_cmp++;
    if (ctl !== 9'b000000001) begin n_bad++; $display("FAIL load_exec ctl=%b exp=%b", ctl, 9'b000000001); end
    dmem_ack = 1'b1;               // spurious: arrives in EXEC
    step();
    dmem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (dmem_req === 1'b1) req_cycles++;
      n_cmp++;
      if (ctl !== 9'b010000001) begin n_bad++; $display("FAIL load_mem%0d ctl=%b exp=%b", c, ctl, 9'b010000001); end
      if (c == 2) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    n_cmp++;
    if (req_cycles !== 3) begin n_bad++; $display("FAIL load_req_len got=%0d exp=3", req_cycles); end
    n_cmp++;
    if (ctl !== 9'b000100001) begin n_bad++; $display("FAIL load_wb ctl=%b exp=%b", ctl, 9'b000100001); end
    step();
    n_cmp++;
    if (ctl !== 9'b100010000) begin n_bad++; $display("FAIL load_pc_en ctl=%b exp=%b", ctl, 9'b100010000); end
    $display("txn LOAD 3028 dmem_req_cycles=%0d", req_cycles);
  endtask

  task automatic test_jal();
    step();                         // one fetch wait cycle
    n_cmp++;
    if (ctl !== 9'b100000000) begin n_bad++; $display("FAIL jal_fwait ctl=%b exp=%b", ctl, 9'b100000000); end
    fetch(16'h5000);
    n_cmp++;
    if ({ctl, link_addr, alu_op} !== {9'b000000010, 3'd7, 4'd5}) begin
      n_bad++; $display("FAIL jal_decode ctl=%b link=%0d op=%0d exp %b/7/5", ctl, link_addr, alu_op, 9'b000000010);
    end
    step();
    n_cmp++;
    if (ctl !== 9'b000000010) begin n_bad++; $display("FAIL jal_exec ctl=%b exp=%b", ctl, 9'b000000010); end
    step();
    n_cmp++;
    if (ctl !== 9'b000100010) begin n_bad++; $display("FAIL jal_wb ctl=%b exp=%b", ctl, 9'b000100010); end
    step();
    n_cmp++;
    if (ctl !== 9'b100010000) begin n_bad++; $display("FAIL jal_pc_en ctl=%b exp=%b", ctl, 9'b100010000); end
    $display("txn JAL 5000");
  endtask

  task automatic test_store();
    fetch(16'h4000);
    step();
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL store_exec ctl=%b exp=%b", ctl, 9'b000000000); end
    step();
    n_cmp++;
    if (ctl !== 9'b011000000) begin n_bad++; $display("FAIL store_mem ctl=%b exp=%b", ctl, 9'b011000000); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    n_cmp++;
    if (ctl !== 9'b100010000) begin n_bad++; $display("FAIL store_pc_en ctl=%b exp=%b", ctl, 9'b100010000); end
    $display("txn STORE 4000");
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [2];
    prog[0] = 16'h0000;
    prog[1] = 16'h6000;
    for (int k = 0; k < 2; k++) begin
      fetch(prog[k]);
      step();
      n_cmp++;
      if ({ctl, alu_op} !== {9'b000000000, prog[k][15:12]}) begin
        n_bad++; $display("FAIL b2b_exec%0d ctl=%b op=%0d exp %b/%0d", k, ctl, alu_op, 9'b000000000, prog[k][15:12]);
      end
      step();
      n_cmp++;
      if (ctl !== 9'b100010000) begin n_bad++; $display("FAIL b2b_pc_en%0d ctl=%b exp=%b", k, ctl, 9'b100010000); end
      $display("txn 3-cycle instr %h", prog[k]);
    end
  endtask

  task automatic test_reset_mid_mem();
    fetch(16'h3028);
    step();
    step();
    n_cmp++;
    if (ctl !== 9'b010000001) begin n_bad++; $display("FAIL abort_mem ctl=%b exp=%b", ctl, 9'b010000001); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ctl, rd_addr, rt_addr, rs_addr, link_addr, alu_op} !== {9'b000000000, 3'd0, 3'd0, 3'd0, 3'd7, 4'd0}) begin
      n_bad++; $display("FAIL abort_reset ctl=%b rt=%0d link=%0d op=%0d exp 0/0/7/0", ctl, rt_addr, link_addr, alu_op);
    end
    dmem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    dmem_ack = 1'b0;
    step();
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL abort_idle ctl=%b exp=%b", ctl, 9'b000000000); end
    $display("txn LOAD aborted by reset in MEM");
  endtask

  task automatic test_halt();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(16'h7000);
    step();
    n_cmp++;
    if (ctl !== 9'b000001000) begin n_bad++; $display("FAIL halt_legal ctl=%b exp=%b", ctl, 9'b000001000); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(16'hF000);
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL illegal_decode ctl=%b exp=%b", ctl, 9'b000000000); end
    step();
    n_cmp++;
    if (ctl !== 9'b000001100) begin n_bad++; $display("FAIL illegal_halt ctl=%b exp=%b", ctl, 9'b000001100); end
    start = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1A50; dmem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if ({ctl, alu_op} !== {9'b000001100, 4'hF}) begin
        n_bad++; $display("FAIL halt_stuck%0d ctl=%b op=%0d exp %b/15", c, ctl, alu_op, 9'b000001100);
      end
    end
    start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 9'b000000000) begin n_bad++; $display("FAIL illegal_clear ctl=%b exp=%b", ctl, 9'b000000000); end
    step();
    rst_n = 1'b1;
    $display("txn HALT 7000 and illegal F000");
  endtask

  initial begin
    test_reset();
    test_spurious_idle();
    test_alu();
    test_load_wait();
    test_jal();
    test_store();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
